// File: rtl/fifo_lvl.sv
// Single-clock level FIFO with count, almost-full/empty levels, flush and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; otherwise reads have 1-cycle latency.
module fifo_lvl #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 13,
  parameter int AFULL_TH   = 2**DATA_DEPTH-4,
  parameter int AEMPTY_TH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_res_n,
  input  logic                  i_flush,
  input  logic                  i_wen,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_afull,
  input  logic                  i_ren,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_rvalid,
  output logic                  o_empty,
  output logic                  o_aempty,
  output logic [DATA_DEPTH:0]   o_count,
  output logic                  o_ovf,
  output logic                  o_udf,
  input  logic                  i_clr_err
);
  localparam int AW    = DATA_DEPTH;
  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] FULL_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C   = AFULL_TH[AW:0];
  localparam logic [AW:0] AE_C   = AEMPTY_TH[AW:0];
  localparam logic [AW:0] ONE    = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic        rd_acc, wr_acc, ovf_set, udf_set;

  // Extra pointer MSB separates full from empty, so every entry is usable.
  assign o_count  = wptr - rptr;
  assign o_empty  = (wptr == rptr);
  assign o_full   = (o_count == FULL_C);
  assign o_afull  = (o_count >= AF_C);
  assign o_aempty = (o_count <= AE_C);

  // Flush suppresses both ports and any error flag for that cycle.
  assign rd_acc  = i_ren & ~o_empty & ~i_flush;
  assign wr_acc  = i_wen & (~o_full | rd_acc) & ~i_flush;
  assign ovf_set = i_wen & ~wr_acc & ~i_flush;
  assign udf_set = i_ren & o_empty & ~i_flush;

  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    if (i_flush) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
    end else begin
      if (wr_acc) wptr_nxt = wptr + ONE;
      if (rd_acc) rptr_nxt = rptr + ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      wptr  <= '0;
      rptr  <= '0;
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      o_ovf <= ovf_set | (o_ovf & ~i_clr_err);
      o_udf <= udf_set | (o_udf & ~i_clr_err);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc && i_res_n) mem[wptr[AW-1:0]] <= i_data;
  end

`ifdef FIFO_FWFT_EN
  // Head register pre-reads the entry the read pointer will address next cycle;
  // bypass covers a write landing in that same slot (empty FIFO being filled).
  logic [DATA_WIDTH-1:0] head;
  logic [AW:0]           rd_next;

  assign rd_next = i_res_n ? rptr_nxt : '0;

  always_ff @(posedge i_clk) begin
    if (wr_acc && i_res_n && (wptr[AW-1:0] == rd_next[AW-1:0])) head <= i_data;
    else                                                        head <= mem[rd_next[AW-1:0]];
  end

  assign o_data   = head;
  assign o_rvalid = ~o_empty;
`else
  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      o_data   <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= rd_acc;
      if (rd_acc) o_data <= mem[rptr[AW-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed bench for fifo_lvl at 4 entries; follows FIFO_FWFT_EN when defined.
module tb_fifo_lvl;
  localparam int DW = 8;
  localparam int DD = 2;

  logic          i_clk = 1'b0;
  logic          i_res_n, i_flush, i_wen, i_ren, i_clr_err;
  logic [DW-1:0] i_data;
  logic          o_full, o_afull, o_rvalid, o_empty, o_aempty, o_ovf, o_udf;
  logic [DW-1:0] o_data;
  logic [DD:0]   o_count;

  int tests = 0;
  int fails = 0;

`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  fifo_lvl #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
    .i_clk(i_clk), .i_res_n(i_res_n), .i_flush(i_flush), .i_wen(i_wen), .i_data(i_data),
    .o_full(o_full), .o_afull(o_afull), .i_ren(i_ren), .o_data(o_data), .o_rvalid(o_rvalid),
    .o_empty(o_empty), .o_aempty(o_aempty), .o_count(o_count), .o_ovf(o_ovf), .o_udf(o_udf),
    .i_clr_err(i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    i_wen = 1'b1; i_data = d;
    tick();
    i_wen = 1'b0;
  endtask

  // One accepted read of an expected word, in whichever output mode is built.
  task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
    if (FWFT) begin
      chk({tag, "_rvalid"}, {31'd0, o_rvalid}, 32'd1);
      chk({tag, "_data"}, {24'd0, o_data}, {24'd0, exp});
      i_ren = 1'b1; tick(); i_ren = 1'b0;
    end else begin
      i_ren = 1'b1; tick(); i_ren = 1'b0;
      chk({tag, "_rvalid"}, {31'd0, o_rvalid}, 32'd1);
      chk({tag, "_data"}, {24'd0, o_data}, {24'd0, exp});
    end
  endtask

  initial begin
    i_res_n = 1'b0; i_flush = 1'b0; i_wen = 1'b0; i_ren = 1'b0; i_clr_err = 1'b0; i_data = '0;
    tick(); tick();
    i_res_n = 1'b1;
    tick();

    // 1: reset state
    chk("rst_empty",  {31'd0, o_empty},  32'd1);
    chk("rst_aempty", {31'd0, o_aempty}, 32'd1);
    chk("rst_count",  {29'd0, o_count},  32'd0);
    chk("rst_full",   {31'd0, o_full},   32'd0);
    chk("rst_afull",  {31'd0, o_afull},  32'd0);
    chk("rst_ovf",    {31'd0, o_ovf},    32'd0);
    chk("rst_udf",    {31'd0, o_udf},    32'd0);
    chk("rst_rvalid", {31'd0, o_rvalid}, 32'd0);

    // 2: fill and drain with level flags
    for (int i = 0; i < 4; i++) begin
      push(8'hA1 + 8'(i));
      chk("fill_count",  {29'd0, o_count},  32'(i + 1));
      chk("fill_afull",  {31'd0, o_afull},  32'(i >= 2));
      chk("fill_full",   {31'd0, o_full},   32'(i == 3));
      chk("fill_aempty", {31'd0, o_aempty}, 32'(i == 0));
    end
    if (FWFT) chk("fwft_head_pre", {24'd0, o_data}, 32'hA1);
    for (int i = 0; i < 4; i++) begin
      pop_chk("drain", 8'hA1 + 8'(i));
      chk("drain_count", {29'd0, o_count}, 32'(3 - i));
    end
    tick();
    chk("drain_rvalid_end", {31'd0, o_rvalid}, 32'd0);
    chk("drain_empty",      {31'd0, o_empty},  32'd1);
    if (!FWFT) chk("drain_hold", {24'd0, o_data}, 32'hA4);

    // 3: overflow while full, sticky until cleared
    for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
    push(8'h55);
    chk("ovf_set",   {31'd0, o_ovf},   32'd1);
    chk("ovf_count", {29'd0, o_count}, 32'd4);
    tick();
    chk("ovf_sticky", {31'd0, o_ovf}, 32'd1);
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
    chk("ovf_clr", {31'd0, o_ovf}, 32'd0);

    // 4: full with simultaneous write and read
    if (FWFT) chk("fr_head", {24'd0, o_data}, 32'hA1);
    i_wen = 1'b1; i_ren = 1'b1; i_data = 8'h66;
    tick();
    i_wen = 1'b0; i_ren = 1'b0;
    chk("fr_count", {29'd0, o_count}, 32'd4);
    chk("fr_ovf",   {31'd0, o_ovf},   32'd0);
    if (!FWFT) chk("fr_data", {24'd0, o_data}, 32'hA1);
    pop_chk("fr_d2", 8'hA2);
    pop_chk("fr_d3", 8'hA3);
    pop_chk("fr_d4", 8'hA4);
    pop_chk("fr_d5", 8'h66);
    chk("fr_empty", {31'd0, o_empty}, 32'd1);

    // 5: underflow, then write+read on empty
    tick();
    i_ren = 1'b1; tick(); i_ren = 1'b0;
    chk("udf_set",    {31'd0, o_udf},    32'd1);
    chk("udf_rvalid", {31'd0, o_rvalid}, 32'd0);
    chk("udf_count",  {29'd0, o_count},  32'd0);
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
    chk("udf_clr", {31'd0, o_udf}, 32'd0);
    i_wen = 1'b1; i_ren = 1'b1; i_data = 8'h77;
    tick();
    i_wen = 1'b0; i_ren = 1'b0;
    chk("ew_count",  {29'd0, o_count},  32'd1);
    chk("ew_udf",    {31'd0, o_udf},    32'd1);
    chk("ew_rvalid", {31'd0, o_rvalid}, 32'(FWFT));
    pop_chk("ew_pop", 8'h77);
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;

    // 6: flush wins over write; then pointer wrap
    push(8'hB0); push(8'hB1); push(8'hB2);
    chk("fl_pre_count", {29'd0, o_count}, 32'd3);
    i_flush = 1'b1; i_wen = 1'b1; i_data = 8'hC0;
    tick();
    i_flush = 1'b0; i_wen = 1'b0;
    chk("fl_count",  {29'd0, o_count},  32'd0);
    chk("fl_empty",  {31'd0, o_empty},  32'd1);
    chk("fl_ovf",    {31'd0, o_ovf},    32'd0);
    chk("fl_rvalid", {31'd0, o_rvalid}, 32'd0);
    push(8'hC1);
    pop_chk("fl_after", 8'hC1);
    push(8'hE0);
    for (int i = 0; i < 20; i++) begin
      push(8'hD0 + 8'(i));
      pop_chk("wrap", (i == 0) ? 8'hE0 : 8'hD0 + 8'(i - 1));
      chk("wrap_count", {29'd0, o_count}, 32'd1);
    end
    pop_chk("wrap_last", 8'hE3);
    chk("wrap_empty", {31'd0, o_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
